// File: rtl/raster_addr_gen.sv
// Pipelined raster-position to frame-buffer / text-register address generator.
// Two register stages; the frame-buffer row base comes from an accumulator, not a multiplier.
module raster_addr_gen #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int GAME_X0     = 160,
    parameter int GAME_W      = 320,
    parameter int GAME_Y0     = 0,
    parameter int GAME_H      = 480,
    parameter int FB_AW       = 18,
    parameter int TXT_X0      = 0,
    parameter int TXT_Y0      = 288,
    parameter int TXT_COLS    = 10,
    parameter int TXT_ROWS    = 6,
    parameter int CHAR_W_LOG2 = 4,
    parameter int CHAR_H_LOG2 = 5,
    parameter int REG_AW      = 6
) (
    input  logic                   pixel_clk,
    input  logic                   reset,
    input  logic [9:0]             DrawX,
    input  logic [9:0]             DrawY,
    output logic [FB_AW-1:0]       fb_addr,
    output logic                   fb_oe,
    output logic [REG_AW-1:0]      reg_addr,
    output logic                   txt_valid,
    output logic [CHAR_W_LOG2-1:0] glyph_x,
    output logic [CHAR_H_LOG2-1:0] glyph_y,
    output logic [9:0]             txt_off_y
);

    localparam int TXT_W   = TXT_COLS << CHAR_W_LOG2;
    localparam int TXT_H   = TXT_ROWS << CHAR_H_LOG2;
    localparam int SUM_W   = ((FB_AW > 11) ? FB_AW : 11) + 1;
    localparam int PROD_W  = 24;

    localparam logic [10:0] GX0 = 11'(GAME_X0);
    localparam logic [10:0] GY0 = 11'(GAME_Y0);
    localparam logic [10:0] GW  = 11'(GAME_W);
    localparam logic [10:0] GH  = 11'(GAME_H);
    localparam logic [10:0] TX0 = 11'(TXT_X0);
    localparam logic [10:0] TY0 = 11'(TXT_Y0);
    localparam logic [10:0] TW  = 11'(TXT_W);
    localparam logic [10:0] TH  = 11'(TXT_H);
    localparam logic [9:0]  GX_LAST = 10'(GAME_X0 + GAME_W - 1);
    localparam logic [9:0]  GY_LAST = 10'(GAME_Y0 + GAME_H - 1);

    if (longint'(GAME_W) * longint'(GAME_H) > (64'd1 << FB_AW)) begin : g_fb_range
        $error("game window does not fit in FB_AW address bits");
    end
    if (TXT_COLS * TXT_ROWS > (1 << REG_AW)) begin : g_reg_range
        $error("text window does not fit in REG_AW index bits");
    end
    if (GAME_X0 + GAME_W > H_RES || GAME_Y0 + GAME_H > V_RES) begin : g_game_bounds
        $error("game window exceeds active raster");
    end
    if (TXT_X0 + TXT_W > H_RES || TXT_Y0 + TXT_H > V_RES) begin : g_txt_bounds
        $error("text window exceeds active raster");
    end

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       game;
        logic       txt;
    } s1_t;

    s1_t              s1;
    logic [FB_AW-1:0] row_base, row_base_nxt;

    // Window membership as one unsigned compare: a coordinate left of the
    // origin wraps to a large offset and fails the length test.
    function automatic logic in_range(input logic [9:0] v, input logic [10:0] lo,
                                      input logic [10:0] len);
        logic [10:0] off;
        off = {1'b0, v} - lo;
        return off < len;
    endfunction

    logic in_game, in_txt;
    always_comb begin
        in_game = in_range(DrawX, GX0, GW) && in_range(DrawY, GY0, GH);
        in_txt  = in_range(DrawX, TX0, TW) && in_range(DrawY, TY0, TH);
    end

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
        end else begin
            s1.x    <= DrawX;
            s1.y    <= DrawY;
            s1.game <= in_game;
            s1.txt  <= in_txt;
        end
    end

    logic              game_rows;
    logic [10:0]       gx_off;
    logic [10:0]       tx_off;
    logic [9:0]        ty_off;
    logic [FB_AW-1:0]  fb_addr_nxt;
    logic [REG_AW-1:0] reg_addr_nxt;

    always_comb begin
        game_rows = in_range(s1.y, GY0, GH);
        gx_off    = {1'b0, s1.x} - GX0;
        tx_off    = {1'b0, s1.x} - TX0;
        ty_off    = s1.y - TY0[9:0];
        fb_addr_nxt  = FB_AW'(SUM_W'(row_base) + SUM_W'(gx_off));
        reg_addr_nxt = REG_AW'(PROD_W'(ty_off >> CHAR_H_LOG2) * PROD_W'(TXT_COLS)
                              + PROD_W'(tx_off >> CHAR_W_LOG2));
    end

    // Rows outside the game window re-zero the base, so any raster glitch or
    // mid-frame reset heals by the next vertical blanking.
    always_comb begin
        row_base_nxt = row_base;
        if (!game_rows) begin
            row_base_nxt = '0;
        end else if (s1.x == GX_LAST) begin
            row_base_nxt = (s1.y == GY_LAST) ? '0 : row_base + FB_AW'(GAME_W);
        end
    end

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            row_base  <= '0;
            fb_addr   <= '0;
            fb_oe     <= 1'b0;
            reg_addr  <= '0;
            txt_valid <= 1'b0;
            glyph_x   <= '0;
            glyph_y   <= '0;
            txt_off_y <= '0;
        end else begin
            row_base  <= row_base_nxt;
            fb_oe     <= s1.game;
            fb_addr   <= s1.game ? fb_addr_nxt : '0;
            txt_valid <= s1.txt;
            reg_addr  <= s1.txt ? reg_addr_nxt : '0;
            glyph_x   <= s1.txt ? tx_off[CHAR_W_LOG2-1:0] : '0;
            glyph_y   <= s1.txt ? ty_off[CHAR_H_LOG2-1:0] : '0;
            txt_off_y <= ty_off;
        end
    end

endmodule

// File: doc/raster_addr_gen.md
Name: raster_addr_gen

Overview:
- Parametrised, pipelined successor to the combinational pixel-to-address calculator in the HDMI text controller.
- Takes the VGA/HDMI raster position (DrawX, DrawY) and produces, with fixed 2-cycle latency:
  - a frame-buffer read address and enable for a configurable game window;
  - a text-register index, plus glyph-local pixel coordinates, for a configurable text window.
- The frame-buffer address comes from a running row-base accumulator, not a multiplier.
- Sits between the VGA controller and the frame-buffer BRAM / slv_reg array.

Parameters:
- H_RES, 640, active pixels per line
- V_RES, 480, active lines per frame
- GAME_X0, 160, first game-window column
- GAME_W, 320, game-window width in pixels
- GAME_Y0, 0, first game-window row
- GAME_H, 480, game-window height in lines
- FB_AW, 18, frame-buffer address width
- TXT_X0, 0, first text-window column
- TXT_Y0, 288, first text-window row
- TXT_COLS, 10, characters per text line
- TXT_ROWS, 6, text lines
- CHAR_W_LOG2, 4, log2 glyph width (16 px)
- CHAR_H_LOG2, 5, log2 glyph height (32 px)
- REG_AW, 6, text register index width

Ports:
- pixel_clk, in, 1, pixel clock; all state on rising edge
- reset, in, 1, asynchronous active-high reset
- DrawX, in, 10, current raster column, 0..799 incl. blanking
- DrawY, in, 10, current raster row, 0..524 incl. blanking
- fb_addr, out, FB_AW, frame-buffer read address
- fb_oe, out, 1, frame-buffer read enable (pixel in game window)
- reg_addr, out, REG_AW, text register index
- txt_valid, out, 1, pixel in text window
- glyph_x, out, CHAR_W_LOG2, column within glyph
- glyph_y, out, CHAR_H_LOG2, row within glyph
- txt_off_y, out, 10, DrawY - TXT_Y0 (mod 2^10), for font-ROM addressing

Behaviour:
- Reset: every output and internal register is cleared to 0 asynchronously; row base = 0.
- Pipeline:
  - S1 registers DrawX, DrawY and both window flags.
  - S2 registers all outputs.
  - Output at cycle n+2 corresponds to the input at cycle n; all outputs stay mutually aligned.
- Game window: GAME_X0 <= X < GAME_X0+GAME_W and GAME_Y0 <= Y < GAME_Y0+GAME_H, unsigned compares.
  - In window: fb_oe=1, fb_addr = row_base + (X - GAME_X0).
  - Outside: fb_oe=0, fb_addr=0.
- Row base accumulator, updated from S1 values, one update per cycle at most:
  - If Y is outside the game rows: row_base <= 0 (resync point; vertical blanking guarantees one per frame).
  - Else, if X == GAME_X0+GAME_W-1:
    - last game row: row_base <= 0;
    - otherwise: row_base <= row_base + GAME_W.
  - Else: hold.
- Raster order is required. Non-raster input yields unspecified fb_addr until the next resync; no error flag.
- Reset mid-frame: row_base = 0; addresses are wrong until the first row outside the game window, then correct.
- Text window: TXT_X0 <= X < TXT_X0+(TXT_COLS<<CHAR_W_LOG2) and TXT_Y0 <= Y < TXT_Y0+(TXT_ROWS<<CHAR_H_LOG2).
  - In window:
    - txt_valid=1
    - reg_addr = ((Y-TXT_Y0)>>CHAR_H_LOG2)*TXT_COLS + ((X-TXT_X0)>>CHAR_W_LOG2), constant multiply
    - glyph_x = (X-TXT_X0) low bits
    - glyph_y = (Y-TXT_Y0) low bits
  - Outside: txt_valid=0; reg_addr, glyph_x, glyph_y = 0.
- txt_off_y is always driven, wrapping modulo 2^10, regardless of window.
- Windows may overlap; both enables may be 1 on the same pixel, and the consumer arbitrates.
- Widths: intermediates are sized for the max product, then truncated to FB_AW / REG_AW.
- Elaboration assertions:
  - GAME_W*GAME_H <= 2^FB_AW
  - TXT_COLS*TXT_ROWS <= 2^REG_AW
  - both windows lie within H_RES x V_RES

Test Plan:
- Assert reset mid-scan with defaults -> all outputs 0 immediately; after release, a full frame gives fb_addr = Y*320+(X-160) at every in-window pixel from the second frame on.
- (X,Y)=(160,0) then (479,0) then (160,1) in raster sweep -> 2 cycles later fb_addr 0, 319, 320; fb_oe=1; X=159 or 480 -> fb_oe=0, fb_addr=0.
- (X,Y)=(479,479) -> fb_addr=153599; the next in-window pixel after vertical blanking (160,0) -> fb_addr=0.
- Text (X,Y)=(0,288) -> reg_addr 0; (159,479) -> reg_addr 59, glyph_x 15, glyph_y 31, txt_off_y 191; (160,288) and (0,287) -> txt_valid=0.
- Override GAME_Y0=40, GAME_H=240, GAME_X0=0, GAME_W=640 -> (0,40) gives 0 and (639,279) gives 153599; rows 0..39 give fb_oe=0.
- Latency check: single-cycle pulse into the window -> fb_oe high for exactly one cycle, exactly 2 cycles later.
